// File: rtl/sq_wave_pkg.sv
// Shared definitions for the square-wave driver/receiver family:
// FSM state encoding, default counter width and the nominal system clock.
package sq_wave_pkg;

  localparam int CLK_HZ              = 27_000_000;
  localparam int CNT_W_DEFAULT       = 10;
  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  typedef enum logic [0:0] {
    IDLE    = ST_IDLE,
    MEASURE = ST_MEASURE
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
// Latency from the input edge to the rise pulse is SYNC_STAGES+1 clocks.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: all state here uses non-blocking assignments so each flop samples the previous cycle's value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/square_wave_phase_detector.sv
// Measures the reference period and the reference-to-signal rising-edge lag,
// in clk counts, once per reference period; flags a lost reference.
module square_wave_phase_detector
  import sq_wave_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ref_in,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             phase_valid,
  output logic             ref_lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             ref_rise;
  logic             sig_rise;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] phase_lat;
  logic             sig_seen;
  logic             cnt_full;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_ref_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ref_in),
    .rise (ref_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sig_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sig_in),
    .rise (sig_rise)
  );

  assign cnt_full = (cnt == CNT_MAX);

  // Window time is counted from the ref_rise cycle itself: at any cycle the
  // elapsed clocks are cnt+1, which is used for both period and phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      phase_lat   <= '0;
      sig_seen    <= 1'b0;
      meas_valid  <= 1'b0;
      ref_lost    <= 1'b0;
      period_cnt  <= '0;
      phase_cnt   <= '0;
      phase_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      ref_lost   <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt      <= '0;
          sig_seen <= 1'b0;
          if (ref_rise) begin
            state     <= ST_MEASURE;
            sig_seen  <= sig_rise;
            phase_lat <= '0;
          end
        end
        ST_MEASURE: begin
          if (ref_rise && !cnt_full) begin
            period_cnt  <= cnt + 1'b1;
            phase_cnt   <= phase_lat;
            phase_valid <= sig_seen;
            meas_valid  <= 1'b1;
            cnt         <= '0;
            sig_seen    <= sig_rise;
            phase_lat   <= '0;
          end else if (cnt_full) begin
            // Window too long to report; a coincident ref edge reopens it.
            ref_lost  <= 1'b1;
            cnt       <= '0;
            sig_seen  <= ref_rise & sig_rise;
            phase_lat <= '0;
            if (!ref_rise) state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (sig_rise && !sig_seen) begin
              phase_lat <= cnt + 1'b1;
              sig_seen  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_square_wave_phase_detector.sv
// Directed bench for square_wave_phase_detector with an edge-timestamp model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_square_wave_phase_detector;

  localparam int CNT_W       = 10;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int WIN_LIMIT   = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ref_in;
  logic             sig_in;
  logic             meas_valid;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] phase_cnt;
  logic             phase_valid;
  logic             ref_lost;

  always #5 clk = ~clk;

  square_wave_phase_detector #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ref_in     (ref_in),
    .sig_in     (sig_in),
    .meas_valid (meas_valid),
    .period_cnt (period_cnt),
    .phase_cnt  (phase_cnt),
    .phase_valid(phase_valid),
    .ref_lost   (ref_lost)
  );

  // Model: timestamps sampled input edges, closes windows by elapsed time,
  // and schedules each result LAT clocks after the closing edge.
  typedef struct {
    int due;
    bit lost;
    int period;
    int phase;
    bit pv;
  } evt_t;

  evt_t q[$];
  int   m_cyc, t_open, m_phase;
  bit   win_open, seen, ref_prev, sig_prev;
  bit   exp_meas, exp_lost, exp_pv;
  int   exp_period, exp_phase;

  always @(posedge clk or negedge rst_n) begin : model
    bit   r_edge, s_edge;
    int   age;
    evt_t ev;
    if (!rst_n) begin
      q.delete();
      m_cyc = 0; t_open = 0; m_phase = 0;
      win_open = 0; seen = 0; ref_prev = 0; sig_prev = 0;
      exp_meas = 0; exp_lost = 0; exp_pv = 0; exp_period = 0; exp_phase = 0;
    end else begin
      m_cyc++;
      exp_meas = 0;
      exp_lost = 0;
      if (q.size() != 0 && q[0].due == m_cyc) begin
        ev = q.pop_front();
        if (ev.lost) exp_lost = 1;
        else begin
          exp_meas = 1; exp_period = ev.period; exp_phase = ev.phase; exp_pv = ev.pv;
        end
      end
      r_edge = ref_in && !ref_prev;
      s_edge = sig_in && !sig_prev;
      ref_prev = ref_in;
      sig_prev = sig_in;
      age = m_cyc - t_open;
      if (win_open && age >= WIN_LIMIT) begin
        q.push_back('{due: m_cyc + LAT, lost: 1'b1, period: 0, phase: 0, pv: 1'b0});
        win_open = 0;
      end else if (win_open && r_edge) begin
        q.push_back('{due: m_cyc + LAT, lost: 1'b0, period: age,
                      phase: seen ? m_phase : 0, pv: seen});
        win_open = 0;
      end
      if (r_edge && !win_open) begin
        win_open = 1; t_open = m_cyc; seen = 0; m_phase = 0;
      end
      if (win_open && s_edge && !seen) begin
        seen = 1; m_phase = m_cyc - t_open;
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int tb_tick = 0;
  int meas_total = 0;
  int lost_total = 0;
  int last_meas_tick = 0;
  int last_lost_tick = 0;
  int edge_tick = 0;
  int base_meas = 0;
  int base_lost = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at tick %0d: got %0d, expected %0d", name, tb_tick, got, want);
    end
  endtask

  task automatic tick(input bit r, input bit s);
    @(negedge clk);
    tb_tick++;
    check("meas_valid", 32'(meas_valid), 32'(exp_meas));
    check("ref_lost", 32'(ref_lost), 32'(exp_lost));
    check("period_cnt", 32'(period_cnt), exp_period);
    check("phase_cnt", 32'(phase_cnt), exp_phase);
    check("phase_valid", 32'(phase_valid), 32'(exp_pv));
    if (meas_valid === 1'b1) begin meas_total++; last_meas_tick = tb_tick; end
    if (ref_lost === 1'b1)   begin lost_total++; last_lost_tick = tb_tick; end
    ref_in = r;
    sig_in = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic snap();
    base_meas = meas_total;
    base_lost = lost_total;
  endtask

  // 50% duty reference; sig is the reference delayed by 'delay' clocks, with an
  // optional 10-clock dip so it rises again at 'extra_at' within its period.
  task automatic run_waves(input int period, input int n, input int delay,
                           input bit sig_en, input int extra_at, input int reset_at);
    int pos, sp;
    bit r, s;
    for (int t = 0; t < n * period; t++) begin
      pos = t % period;
      r = (pos < period / 2);
      s = 1'b0;
      if (sig_en && t >= delay) begin
        sp = (t - delay) % period;
        s = (sp < period / 2);
        if (extra_at > 0 && sp >= extra_at - 10 && sp < extra_at) s = 1'b0;
      end
      tick(r, s);
      if (pos == 0) edge_tick = tb_tick;
      if (t == reset_at) rst_n = 1'b0;
      if (t == reset_at + 2) begin
        check("rst_meas_valid", 32'(meas_valid), 0);
        check("rst_period", 32'(period_cnt), 0);
        check("rst_phase", 32'(phase_cnt), 0);
        check("rst_phase_valid", 32'(phase_valid), 0);
        check("rst_ref_lost", 32'(ref_lost), 0);
      end
      if (t == reset_at + 3) begin
        rst_n = 1'b1;
        snap();
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ref_in = 1'b0;
    sig_in = 1'b0;
    idle(4);
    check("reset_period", 32'(period_cnt), 0);
    check("reset_meas_valid", 32'(meas_valid), 0);
    check("reset_ref_lost", 32'(ref_lost), 0);
    rst_n = 1'b1;
    idle(3);

    // Nominal 674-clock period, signal lagging by 21 clocks.
    run_waves(674, 5, 21, 1'b1, 0, -10);
    check("nom_period", 32'(period_cnt), 674);
    check("nom_phase", 32'(phase_cnt), 21);
    check("nom_phase_valid", 32'(phase_valid), 1);
    check("nom_model_period", exp_period, 674);
    check("nom_model_phase", exp_phase, 21);
    check("nom_latency", last_meas_tick - edge_tick, 4);

    // Signal absent.
    run_waves(674, 4, 0, 1'b0, 0, -10);
    check("absent_period", 32'(period_cnt), 674);
    check("absent_phase", 32'(phase_cnt), 0);
    check("absent_phase_valid", 32'(phase_valid), 0);

    // Coincident edges, then with a second signal rise at clock 300.
    run_waves(674, 4, 0, 1'b1, 0, -10);
    check("coinc_period", 32'(period_cnt), 674);
    check("coinc_phase", 32'(phase_cnt), 0);
    check("coinc_phase_valid", 32'(phase_valid), 1);
    run_waves(674, 4, 0, 1'b1, 300, -10);
    check("extra_phase", 32'(phase_cnt), 0);
    check("extra_phase_valid", 32'(phase_valid), 1);

    // Reference stops after one edge.
    run_waves(674, 1, 21, 1'b1, 0, -10);
    snap();
    idle(1200);
    check("timeout_lost_count", lost_total - base_lost, 1);
    check("timeout_meas_count", meas_total - base_meas, 0);
    check("timeout_latency", last_lost_tick - edge_tick, 1028);

    // Restart: two edges give exactly one measurement.
    snap();
    run_waves(674, 2, 21, 1'b1, 0, -10);
    check("restart_meas_count", meas_total - base_meas, 1);
    check("restart_period", 32'(period_cnt), 674);
    check("restart_phase", 32'(phase_cnt), 21);
    check("restart_latency", last_meas_tick - edge_tick, 4);

    // Reset for 3 clocks at clock 400 of the second window.
    run_waves(674, 4, 21, 1'b1, 0, 674 + 400);
    check("post_reset_meas_count", meas_total - base_meas, 1);
    check("post_reset_period", 32'(period_cnt), 674);
    check("post_reset_phase", 32'(phase_cnt), 21);
    check("post_reset_phase_valid", 32'(phase_valid), 1);

    // Longest reportable period.
    snap();
    run_waves(1023, 3, 21, 1'b1, 0, -10);
    check("p1023_meas_count", meas_total - base_meas, 3);
    check("p1023_lost_count", lost_total - base_lost, 0);
    check("p1023_period", 32'(period_cnt), 1023);
    check("p1023_phase", 32'(phase_cnt), 21);
    snap();
    idle(1100);
    check("p1023_tail_lost", lost_total - base_lost, 1);

    // Period just past the limit: every window times out.
    snap();
    run_waves(1025, 3, 21, 1'b1, 0, -10);
    idle(1100);
    check("p1025_meas_count", meas_total - base_meas, 0);
    check("p1025_lost_count", lost_total - base_lost, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
